tt_um_seq_alu_fifo: RTL

//  Sequential successor to the combinational 8-bit adder tile: registered ADD/SUB/ACC/CLR unit, width set by parameter.

---
 rtl/tt_um_seq_alu_fifo.sv | 76 +++++++
 1 files changed

// File: rtl/tt_um_seq_alu_fifo.sv
// tt_um_seq_alu_fifo: registered ADD/SUB/ACC/CLR unit whose results queue in a DEPTH-entry FIFO.
// Define TT_SEQ_ALU_SAT_EN to saturate ADD/ACC overflow and SUB underflow instead of wrapping.
module tt_um_seq_alu_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_op,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_flag,
  output logic [$clog2(DEPTH):0]   out_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_data [DEPTH];
  logic             r_flag [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [CW-1:0]    r_count;
  logic             w_push, w_pop, w_flag;
  logic [WIDTH:0]   w_sum, w_diff, w_raw;
  logic [WIDTH-1:0] w_res;
  assign in_ready  = ena & (r_count != FULL);
  assign out_valid = r_count != '0;
  assign w_push    = in_valid & in_ready;
  assign w_pop     = ena & out_valid & out_ready;
  assign out_count = r_count;
  assign out_data  = out_valid ? r_data[r_rd] : '0;
  assign out_flag  = out_valid & r_flag[r_rd];
  // the extra MSB of each raw result is the carry (sum) or borrow (difference)
  always_comb begin
    w_sum  = {1'b0, (in_op == OP_ACC) ? r_acc : in_a} + {1'b0, (in_op == OP_ACC) ? in_a : in_b};
    w_diff = {1'b0, in_a} - {1'b0, in_b};
    w_raw  = (in_op == OP_SUB) ? w_diff : (in_op == OP_CLR) ? '0 : w_sum;
    w_flag = w_raw[WIDTH];
`ifdef TT_SEQ_ALU_SAT_EN
    w_res  = !w_flag ? w_raw[WIDTH-1:0] : (in_op == OP_SUB) ? '0 : '1;
`else
    w_res  = w_raw[WIDTH-1:0];
`endif
  end
  // ACC and CLR both load the accumulator with the pushed result (CLR's is zero)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_flag[i] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_data[r_wr] <= w_res;
        r_flag[r_wr] <= w_flag;
        r_wr         <= r_wr + AW'(1);
        if (in_op[1]) r_acc <= w_res;
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule
